// File: rtl/keccak_pkg.sv
// keccak_pkg: shared constants and types for the Keccak absorb datapath.
//   - Domain-separation bytes, the closing pad10*1 byte and state geometry.
//   - absorb_state_t: states of the streaming absorb FSM.
//   - lane_xy(): maps a linear lane index i = x + 5y back to (x, y).
package keccak_pkg;

   localparam int RATE_WIDTH  = 11;                // widest legal rate is 1344 bits
   localparam int STATE_BYTES = 200;
   localparam int STATE_BITS  = STATE_BYTES * 8;
   localparam int COUNT_WIDTH = $clog2(168 + 1);   // byte offset inside the largest rate block

   localparam logic [7:0] DS_SHA3  = 8'h06;
   localparam logic [7:0] DS_SHAKE = 8'h1F;
   localparam logic [7:0] PAD_LAST = 8'h80;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ABSORB,
      ST_PERMUTE,
      ST_CARRY,
      ST_PAD,
      ST_DONE
   } absorb_state_t;

   typedef struct packed {
      logic [2:0] x;
      logic [2:0] y;
   } lane_xy_t;

   function automatic lane_xy_t lane_xy(input int unsigned i);
      lane_xy_t r;
      r.x = 3'(i % 5);
      r.y = 3'(i / 5);
      return r;
   endfunction

endpackage

// File: rtl/keccak_byte_xor.sv
// keccak_byte_xor: combinational byte-lane XOR into the 200-byte state view.
//   state_i      : current 1600-bit state, byte b at bits [8b+7:8b]
//   data_i       : up to IN_BYTES source bytes, source byte 0 in [7:0]
//   byte_en_i    : per-source-byte enable; disabled bytes contribute nothing
//   offset_i     : state byte that receives source byte 0
//   rate_bytes_i : bytes at or beyond this offset are never touched
//   state_o      : state_i with the enabled bytes XORed in
// Shared by the ABSORB path (stream beat) and the CARRY path (overflow bytes).
module keccak_byte_xor
   import keccak_pkg::*;
#(
   parameter int IN_BYTES = 32
) (
   input  logic [STATE_BITS-1:0]   state_i,
   input  logic [IN_BYTES*8-1:0]   data_i,
   input  logic [IN_BYTES-1:0]     byte_en_i,
   input  logic [COUNT_WIDTH-1:0]  offset_i,
   input  logic [COUNT_WIDTH-1:0]  rate_bytes_i,
   output logic [STATE_BITS-1:0]   state_o
);

   logic [COUNT_WIDTH:0] pos;
   logic [10:0]          bidx;

   always_comb begin
      // NOTE: every output gets its default before any conditional update so no latch is inferred.
      state_o = state_i;
      pos     = '0;
      bidx    = '0;
      // NOTE: blocking assignments here let each loop iteration build on the previous one.
      for (int j = 0; j < IN_BYTES; j++) begin
         pos  = {1'b0, offset_i} + (COUNT_WIDTH + 1)'(j);
         bidx = {pos[COUNT_WIDTH-1:0], 3'b000};
         if (byte_en_i[j] && (pos < {1'b0, rate_bytes_i})) begin
            state_o[bidx +: 8] = state_o[bidx +: 8] ^ data_i[j*8 +: 8];
         end
      end
   end

endmodule

// File: rtl/keccak_absorb_stream.sv
// keccak_absorb_stream: streaming absorb engine in front of the Keccak permutation.
//   clk, rst_n         : clock, synchronous active-low reset
//   start_i            : begins a message (latches rate_i, ds_i; clears state) in IDLE/DONE
//   rate_i, ds_i       : rate in bits and domain-separation byte
//   s_t*               : byte-keeped input stream with valid/ready handshake
//   state_o            : 1600-bit state, lane i = x + 5y at bits [64i+63:64i]
//   perm_req_o         : held while the state waits for the permutation core
//   perm_done_i/state_i: permutation result, valid in the perm_done_i cycle
//   done_o             : message fully absorbed and final permutation returned
// Beats that overrun a rate block spill their tail into a carry register, which
// is folded into the next block in a dedicated CARRY cycle after the permutation.
module keccak_absorb_stream
   import keccak_pkg::*;
#(
   parameter int IN_WIDTH = 256,
   parameter int IN_BYTES = IN_WIDTH / 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start_i,
   input  logic [RATE_WIDTH-1:0]  rate_i,
   input  logic [7:0]             ds_i,
   input  logic [IN_WIDTH-1:0]    s_tdata,
   input  logic [IN_BYTES-1:0]    s_tkeep,
   input  logic                   s_tlast,
   input  logic                   s_tvalid,
   output logic                   s_tready,
   output logic [STATE_BITS-1:0]  state_o,
   output logic                   perm_req_o,
   input  logic                   perm_done_i,
   input  logic [STATE_BITS-1:0]  state_i,
   output logic                   done_o
);

   localparam int NW = $clog2(IN_BYTES + 1);

   function automatic logic [NW-1:0] popcount(input logic [IN_BYTES-1:0] v);
      logic [NW-1:0] c;
      c = '0;
      for (int j = 0; j < IN_BYTES; j++) c = c + NW'(v[j]);
      return c;
   endfunction

   absorb_state_t          fsm_q, fsm_d;
   logic [STATE_BITS-1:0]  state_q, state_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic [COUNT_WIDTH-1:0] rate_bytes_q, rate_bytes_d;
   logic [7:0]             ds_q, ds_d;
   logic [IN_WIDTH-1:0]    carry_data_q, carry_data_d;
   logic [NW-1:0]          carry_n_q, carry_n_d;
   logic                   carry_valid_q, carry_valid_d;
   logic                   carry_last_q, carry_last_d;
   logic                   pad_pending_q, pad_pending_d;
   logic                   final_q, final_d;

   logic [COUNT_WIDTH-1:0] keep_n;
   logic [COUNT_WIDTH-1:0] space;
   logic [COUNT_WIDTH-1:0] pad_idx;
   logic [IN_WIDTH-1:0]    masked_data;
   logic [IN_WIDTH-1:0]    carry_shift;
   logic [IN_BYTES-1:0]    carry_en;
   logic [IN_WIDTH-1:0]    xor_data;
   logic [IN_BYTES-1:0]    xor_en;
   logic [COUNT_WIDTH-1:0] xor_off;
   logic [STATE_BITS-1:0]  xor_state;

   // Beat bookkeeping: valid byte count, room left in the block, and the
   // overflow bytes realigned to offset 0 for the carry register.
   always_comb begin
      keep_n      = COUNT_WIDTH'(popcount(s_tkeep));
      space       = rate_bytes_q - count_q;
      pad_idx     = rate_bytes_q - 1'b1;
      masked_data = '0;
      carry_en    = '0;
      for (int j = 0; j < IN_BYTES; j++) begin
         masked_data[j*8 +: 8] = s_tkeep[j] ? s_tdata[j*8 +: 8] : 8'h00;
         carry_en[j]           = (j < int'(carry_n_q));
      end
      carry_shift = masked_data >> {space, 3'b000};
   end

   // The XOR unit sees the stream beat in ABSORB and the stored overflow in CARRY.
   always_comb begin
      xor_data = masked_data;
      xor_en   = s_tkeep;
      xor_off  = count_q;
      if (fsm_q == ST_CARRY) begin
         xor_data = carry_data_q;
         xor_en   = carry_en;
         xor_off  = '0;
      end
   end

   keccak_byte_xor #(
      .IN_BYTES (IN_BYTES)
   ) u_byte_xor (
      .state_i      (state_q),
      .data_i       (xor_data),
      .byte_en_i    (xor_en),
      .offset_i     (xor_off),
      .rate_bytes_i (rate_bytes_q),
      .state_o      (xor_state)
   );

   always_comb begin
      fsm_d         = fsm_q;
      state_d       = state_q;
      count_d       = count_q;
      rate_bytes_d  = rate_bytes_q;
      ds_d          = ds_q;
      carry_data_d  = carry_data_q;
      carry_n_d     = carry_n_q;
      carry_valid_d = carry_valid_q;
      carry_last_d  = carry_last_q;
      pad_pending_d = pad_pending_q;
      final_d       = final_q;

      unique case (fsm_q)
         ST_IDLE, ST_DONE: begin
            if (start_i) begin
               state_d       = '0;
               count_d       = '0;
               rate_bytes_d  = COUNT_WIDTH'(rate_i >> 3);
               ds_d          = ds_i;
               carry_valid_d = 1'b0;
               carry_last_d  = 1'b0;
               pad_pending_d = 1'b0;
               final_d       = 1'b0;
               fsm_d         = ST_ABSORB;
            end
         end

         ST_ABSORB: begin
            if (s_tvalid) begin
               state_d = xor_state;
               if (keep_n < space) begin
                  count_d = count_q + keep_n;
                  if (s_tlast) fsm_d = ST_PAD;
               end else if (keep_n == space) begin
                  count_d       = '0;
                  pad_pending_d = s_tlast;
                  fsm_d         = ST_PERMUTE;
               end else begin
                  // Only the low "space" bytes land in this block; the rest wait.
                  carry_data_d  = carry_shift;
                  carry_n_d     = NW'(keep_n - space);
                  carry_valid_d = 1'b1;
                  carry_last_d  = s_tlast;
                  count_d       = '0;
                  fsm_d         = ST_PERMUTE;
               end
            end
         end

         ST_PERMUTE: begin
            if (perm_done_i) begin
               state_d = state_i;
               if (carry_valid_q)      fsm_d = ST_CARRY;
               else if (pad_pending_q) fsm_d = ST_PAD;
               else if (final_q)       fsm_d = ST_DONE;
               else                    fsm_d = ST_ABSORB;
            end
         end

         ST_CARRY: begin
            state_d       = xor_state;
            count_d       = COUNT_WIDTH'(carry_n_q);
            carry_valid_d = 1'b0;
            carry_last_d  = 1'b0;
            fsm_d         = carry_last_q ? ST_PAD : ST_ABSORB;
         end

         ST_PAD: begin
            // Applied in sequence so a shared byte ends up as ds ^ 0x80.
            state_d[{count_q, 3'b000} +: 8] = state_d[{count_q, 3'b000} +: 8] ^ ds_q;
            state_d[{pad_idx, 3'b000} +: 8] = state_d[{pad_idx, 3'b000} +: 8] ^ PAD_LAST;
            pad_pending_d = 1'b0;
            final_d       = 1'b1;
            fsm_d         = ST_PERMUTE;
         end

         default: fsm_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fsm_q         <= ST_IDLE;
         // NOTE: the wide state register is reset too, since state_o must read zero out of reset.
         state_q       <= '0;
         count_q       <= '0;
         rate_bytes_q  <= '0;
         ds_q          <= '0;
         carry_data_q  <= '0;
         carry_n_q     <= '0;
         carry_valid_q <= 1'b0;
         carry_last_q  <= 1'b0;
         pad_pending_q <= 1'b0;
         final_q       <= 1'b0;
      end else begin
         fsm_q         <= fsm_d;
         state_q       <= state_d;
         count_q       <= count_d;
         rate_bytes_q  <= rate_bytes_d;
         ds_q          <= ds_d;
         carry_data_q  <= carry_data_d;
         carry_n_q     <= carry_n_d;
         carry_valid_q <= carry_valid_d;
         carry_last_q  <= carry_last_d;
         pad_pending_q <= pad_pending_d;
         final_q       <= final_d;
      end
   end

   assign state_o    = state_q;
   assign s_tready   = (fsm_q == ST_ABSORB);
   assign perm_req_o = (fsm_q == ST_PERMUTE);
   assign done_o     = (fsm_q == ST_DONE);

endmodule

// File: tb/tb_keccak_absorb_stream.sv
// tb_keccak_absorb_stream: drives whole messages through the absorb engine and
// compares every state presented for permutation, and the final state, with a
// byte-level sponge model (message byte i lands at offset i mod rate, pad10*1
// after the last byte, permutation replaced by bench-chosen values).
module tb_keccak_absorb_stream;
   import keccak_pkg::*;

   localparam int IN_WIDTH = 256;
   localparam int IN_BYTES = IN_WIDTH / 8;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  start_i;
   logic [RATE_WIDTH-1:0] rate_i;
   logic [7:0]            ds_i;
   logic [IN_WIDTH-1:0]   s_tdata;
   logic [IN_BYTES-1:0]   s_tkeep;
   logic                  s_tlast;
   logic                  s_tvalid;
   logic                  s_tready;
   logic [1599:0]         state_o;
   logic                  perm_req_o;
   logic                  perm_done_i;
   logic [1599:0]         state_i;
   logic                  done_o;

   keccak_absorb_stream #(.IN_WIDTH(IN_WIDTH)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .rate_i(rate_i), .ds_i(ds_i),
      .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tvalid(s_tvalid),
      .s_tready(s_tready), .state_o(state_o), .perm_req_o(perm_req_o),
      .perm_done_i(perm_done_i), .state_i(state_i), .done_o(done_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   logic [1599:0] exp_req[$];
   logic [1599:0] perm_out[$];
   logic [1599:0] req_seen[$];
   int            xfer_cyc[$];
   int            done_cyc[$];
   int            req_cyc[$];
   bit            model_on  = 1'b1;
   bit            auto_resp = 1'b1;
   bit            stray_en  = 1'b0;
   bit            fixed_p   = 1'b1;
   int            resp_delay_max = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_state(input string name, input logic [1599:0] act, input logic [1599:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         for (int k = 0; k < 200; k++) begin
            if (act[8*k +: 8] !== exp[8*k +: 8]) begin
               $display("FAIL %s: byte %0d got %02h expected %02h (cycle %0d)",
                        name, k, act[8*k +: 8], exp[8*k +: 8], cyc);
               break;
            end
         end
      end
   endtask

   task automatic timeout(input string name);
      total++;
      bad++;
      $display("FAIL %s: timed out waiting for DUT (cycle %0d)", name, cyc);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   endtask

   function automatic logic [1599:0] rand1600();
      logic [1599:0] v;
      for (int w = 0; w < 50; w++) v[32*w +: 32] = $urandom();
      return v;
   endfunction

   function automatic logic [7:0] byte_of(input logic [1599:0] v, input int k);
      return v[8*k +: 8];
   endfunction

   function automatic logic [1599:0] seen(input int k);
      return (k < req_seen.size()) ? req_seen[k] : '0;
   endfunction

   function automatic int qv(input int q[$], input int k);
      return (k < q.size()) ? q[k] : -100;
   endfunction

   // Compare process: checks each permutation request against the model and
   // the request protocol (state stable, request drops after perm_done_i).
   logic          prev_req  = 1'b0;
   logic          prev_done = 1'b0;
   logic [1599:0] hold;
   always @(negedge clk) begin
      if (rst_n) begin
         if (s_tvalid && s_tready) xfer_cyc.push_back(cyc);
         if (prev_done) check("req_drop_after_done", perm_req_o, 1'b0);
         if (perm_req_o && !prev_req) begin
            req_cyc.push_back(cyc);
            req_seen.push_back(state_o);
            hold = state_o;
            if (model_on) begin
               check("req_expected", exp_req.size() != 0, 1'b1);
               if (exp_req.size() != 0) check_state("req_state", state_o, exp_req.pop_front());
            end
         end else if (perm_req_o) begin
            check_state("req_stable", state_o, hold);
         end
         prev_done = perm_req_o && perm_done_i;
         if (prev_done) done_cyc.push_back(cyc);
         prev_req = perm_req_o;
      end else begin
         prev_req  = 1'b0;
         prev_done = 1'b0;
      end
   end

   // Permutation responder: answers requests after a random delay and, when
   // enabled, fires stray perm_done_i pulses outside PERMUTE.
   initial begin : responder
      int wait_cnt;
      int cur_delay;
      wait_cnt    = 0;
      cur_delay   = 0;
      perm_done_i = 1'b0;
      state_i     = '0;
      forever begin
         @(posedge clk);
         #1;
         if (auto_resp) begin
            perm_done_i = 1'b0;
            if (rst_n && perm_req_o) begin
               if (wait_cnt >= cur_delay) begin
                  perm_done_i = 1'b1;
                  state_i     = (perm_out.size() != 0) ? perm_out.pop_front() : '0;
                  wait_cnt    = 0;
                  cur_delay   = $urandom_range(0, resp_delay_max);
               end else begin
                  wait_cnt++;
               end
            end else begin
               wait_cnt = 0;
               if (stray_en && $urandom_range(0, 7) == 0) begin
                  perm_done_i = 1'b1;
                  state_i     = rand1600();
               end
            end
         end
      end
   end

   task automatic send_beat(input logic [IN_WIDTH-1:0] data, input logic [IN_BYTES-1:0] keep,
                            input logic last);
      int n;
      s_tdata  = data;
      s_tkeep  = keep;
      s_tlast  = last;
      s_tvalid = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (s_tready) break;
         n++;
         if (n > 500) timeout("beat_accept");
      end
      @(posedge clk);
      #1;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      s_tdata  = {IN_WIDTH/32{$urandom()}};
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      forever begin
         @(negedge clk);
         if (done_o) break;
         n++;
         if (n > 3000) timeout("done_wait");
      end
   endtask

   // Runs one complete message and checks every request and the final state.
   task automatic run_msg(input int rate_bits, input logic [7:0] ds, input int len,
                          input bit seq_data, input bit gaps);
      logic [7:0]    msg[$];
      logic [1599:0] plist[$];
      logic [1599:0] s;
      logic [1599:0] p;
      logic [IN_WIDTH-1:0] data;
      logic [IN_BYTES-1:0] keep;
      int r, k_tot, k, pos, nfull, rem, n;

      r     = rate_bits / 8;
      k_tot = len / r + 1;
      exp_req.delete(); perm_out.delete(); req_seen.delete();
      xfer_cyc.delete(); done_cyc.delete(); req_cyc.delete();
      for (int i = 0; i < len; i++) msg.push_back(seq_data ? 8'(i + 1) : 8'($urandom()));
      for (int i = 0; i < k_tot; i++) begin
         p = fixed_p ? {200{8'hA5}} : rand1600();
         plist.push_back(p);
         perm_out.push_back(p);
      end

      // Sponge model: bytes in order, one permutation per full block, then pad.
      s = '0;
      k = 0;
      for (int i = 0; i < len; i++) begin
         pos = i % r;
         s[8*pos +: 8] ^= msg[i];
         if (pos == r - 1) begin
            exp_req.push_back(s);
            s = plist[k];
            k++;
         end
      end
      pos = len % r;
      s[8*pos +: 8]     ^= ds;
      s[8*(r-1) +: 8]   ^= 8'h80;
      exp_req.push_back(s);

      @(posedge clk);
      #1;
      rate_i  = RATE_WIDTH'(rate_bits);
      ds_i    = ds;
      start_i = 1'b1;
      @(posedge clk);
      #1;
      start_i = 1'b0;

      nfull = len / IN_BYTES;
      rem   = len % IN_BYTES;
      for (int b = 0; b <= nfull; b++) begin
         n = (b == nfull) ? rem : IN_BYTES;
         for (int w = 0; w < IN_WIDTH / 32; w++) data[32*w +: 32] = $urandom();
         keep = '0;
         for (int j = 0; j < n; j++) begin
            data[8*j +: 8] = msg[b*IN_BYTES + j];
            keep[j] = 1'b1;
         end
         if (gaps && $urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
         send_beat(data, keep, b == nfull);
      end

      wait_done();
      check_state("final_state", state_o, plist[k_tot-1]);
      check("req_count", req_seen.size(), k_tot);
      check("model_drained", exp_req.size(), 0);
      check("ready_in_done", s_tready, 1'b0);
   endtask

   initial begin : main
      logic [1599:0] lit;
      int rates[5];
      rates = '{576, 832, 1088, 1152, 1344};

      rst_n = 1'b0; start_i = 1'b0; rate_i = '0; ds_i = '0;
      s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tvalid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_state("reset_state", state_o, '0);
      check("reset_ready", s_tready, 1'b0);
      check("reset_perm_req", perm_req_o, 1'b0);
      check("reset_done", done_o, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Empty SHA3-256 message: single pad block.
      run_msg(1088, DS_SHA3, 0, 1'b1, 1'b0);
      lit = '0;
      lit[7:0]         = 8'h06;
      lit[1087:1080]   = 8'h80;
      check_state("empty_pad_block", seen(0), lit);
      check("empty_pad_latency", qv(req_cyc, 0) - qv(xfer_cyc, 0), 2);

      // 136 B SHA3-256: exact fill, back-to-back beats, pad in a second block.
      run_msg(1088, DS_SHA3, 136, 1'b1, 1'b0);
      check("fill_back_to_back", qv(xfer_cyc, 4) - qv(xfer_cyc, 0), 4);
      check("fill_ready_drop", qv(req_cyc, 0) - qv(xfer_cyc, 4), 1);
      check("fill_blk0_b135", byte_of(seen(0), 135), 8'h88);
      check("fill_blk1_b0", byte_of(seen(1), 0), 8'hA3);
      check("fill_blk1_b1", byte_of(seen(1), 1), 8'hA5);
      check("fill_blk1_b135", byte_of(seen(1), 135), 8'h25);

      // SHA3-512 carry: third 32 B beat places 8 B and carries 24 B.
      run_msg(576, DS_SHA3, 96, 1'b1, 1'b0);
      check("carry_ready_drop", qv(req_cyc, 0) - qv(xfer_cyc, 2), 1);
      check("carry_resume", qv(xfer_cyc, 3) - qv(done_cyc, 0), 2);
      check("carry_blk0_b71", byte_of(seen(0), 71), 8'h48);
      check("carry_blk1_b0", byte_of(seen(1), 0), 8'hEC);
      check("carry_blk1_b23", byte_of(seen(1), 23), 8'hC5);
      check("carry_blk1_b24", byte_of(seen(1), 24), 8'hA3);
      check("carry_blk1_b71", byte_of(seen(1), 71), 8'h25);
      check("carry_blk1_b72", byte_of(seen(1), 72), 8'hA5);

      // SHAKE128 167 B: ds and final pad bit share the last rate byte.
      run_msg(1344, DS_SHAKE, 167, 1'b1, 1'b0);
      check("shake_b166", byte_of(seen(0), 166), 8'hA7);
      check("shake_b167", byte_of(seen(0), 167), 8'h9F);
      check("shake_b168", byte_of(seen(0), 168), 8'h00);

      // Reset while a permutation request is pending.
      model_on  = 1'b0;
      auto_resp = 1'b0;
      perm_done_i = 1'b0;
      @(posedge clk);
      #1;
      rate_i = RATE_WIDTH'(576); ds_i = DS_SHA3; start_i = 1'b1;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      for (int b = 0; b < 3; b++) send_beat({IN_WIDTH/32{$urandom()}}, '1, 1'b0);
      begin
         int n;
         n = 0;
         forever begin
            @(negedge clk);
            if (perm_req_o) break;
            n++;
            if (n > 50) timeout("reset_req_wait");
         end
      end
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_perm_req", perm_req_o, 1'b0);
      check("rst_ready", s_tready, 1'b0);
      check("rst_done", done_o, 1'b0);
      check_state("rst_state", state_o, '0);
      @(posedge clk);
      #1;
      perm_done_i = 1'b1;
      state_i     = rand1600();
      @(posedge clk);
      #1;
      perm_done_i = 1'b0;
      @(negedge clk);
      check_state("rst_done_ignored", state_o, '0);
      check("rst_idle_perm_req", perm_req_o, 1'b0);
      check("rst_idle_ready", s_tready, 1'b0);
      model_on  = 1'b1;
      auto_resp = 1'b1;

      // Randomized messages: all rates, both ds values, gaps, stray pulses.
      fixed_p        = 1'b0;
      stray_en       = 1'b1;
      resp_delay_max = 3;
      for (int t = 0; t < 20; t++) begin
         run_msg(rates[$urandom_range(0, 4)], ($urandom_range(0, 1) != 0) ? DS_SHAKE : DS_SHA3,
                 $urandom_range(0, 360), 1'b0, 1'b1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
